// File: rtl/udp_tx_pkg.sv
// Shared types and constants for the UDP transmit frame scheduler.
package udp_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_PAY  = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   localparam logic [15:0] UDP_HDR_LEN    = 16'd8;
   localparam logic [31:0] DEF_DEST_IP    = 32'hEF02_0206;
   localparam logic [15:0] DEF_DEST_PORT0 = 16'd21007;
   localparam logic [15:0] DEF_DEST_PORT1 = 16'd21008;
   localparam logic [7:0]  DEF_TTL        = 8'd64;

endpackage

// File: rtl/udp_rr_arb2.sv
// Two-way round-robin arbiter: the preferred channel is the one after the
// last served; ptr points at ch0 out of reset.
module udp_rr_arb2 (
   input  logic       tx_clk,
   input  logic       tx_rst,
   input  logic [1:0] req,
   input  logic       take,
   output logic       pick,
   output logic       any_req
);

   logic ptr;

   always_comb begin
      any_req = |req;
      pick    = req[ptr] ? ptr : ~ptr;
   end

   always_ff @(posedge tx_clk) begin
      if (tx_rst) begin
         ptr <= 1'b0;
      end else if (take) begin
         ptr <= ~pick;
      end
   end

endmodule

// File: rtl/udp_tx_frame_scheduler.sv
// Schedules two AXIS payload channels onto one UDP header/payload stream with
// length checking and an inter-frame gap. Per-channel frame and error counters
// are built only when UDP_TX_SCHED_STATS_EN is defined.
//
// state | meaning
// IDLE  | wait for a channel request, arbitrate and latch length/port
// HDR   | present header until accepted downstream
// PAY   | pass granted channel's beats through, check length vs tlast
// GAP   | enforce GAP_CYCLES idle cycles after the last beat
module udp_tx_frame_scheduler
   import udp_tx_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 16,
   parameter logic [31:0] DEST_IP    = DEF_DEST_IP,
   parameter logic [15:0] DEST_PORT0 = DEF_DEST_PORT0,
   parameter logic [15:0] DEST_PORT1 = DEF_DEST_PORT1,
   parameter logic [7:0]  TTL        = DEF_TTL
) (
   input  logic        tx_clk,
   input  logic        tx_rst,
   input  logic [31:0] local_ip,
   input  logic [15:0] src_port,
   input  logic [15:0] s0_len,
   input  logic [7:0]  s0_tdata,
   input  logic        s0_tvalid,
   output logic        s0_tready,
   input  logic        s0_tlast,
   input  logic        s0_tuser,
   input  logic [15:0] s1_len,
   input  logic [7:0]  s1_tdata,
   input  logic        s1_tvalid,
   output logic        s1_tready,
   input  logic        s1_tlast,
   input  logic        s1_tuser,
   output logic        tx_udp_hdr_valid,
   input  logic        tx_udp_hdr_ready,
   output logic [5:0]  tx_udp_ip_dscp,
   output logic [1:0]  tx_udp_ip_ecn,
   output logic [7:0]  tx_udp_ip_ttl,
   output logic [31:0] tx_udp_ip_source_ip,
   output logic [31:0] tx_udp_ip_dest_ip,
   output logic [15:0] tx_udp_source_port,
   output logic [15:0] tx_udp_dest_port,
   output logic [15:0] tx_udp_length,
   output logic [15:0] tx_udp_checksum,
   output logic [7:0]  tx_udp_payload_axis_tdata,
   output logic        tx_udp_payload_axis_tvalid,
   input  logic        tx_udp_payload_axis_tready,
   output logic        tx_udp_payload_axis_tlast,
   output logic        tx_udp_payload_axis_tuser,
   output logic        len_err,
   output logic        grant
`ifdef UDP_TX_SCHED_STATS_EN
   ,
   output logic [31:0] frames0,
   output logic [31:0] frames1,
   output logic [15:0] errs
`endif
);

   localparam logic [15:0] GAP_LOAD = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

   state_t      state, state_nxt;
   logic        grant_q;
   logic [15:0] len_q, beat_cnt, gap_cnt;
   logic [15:0] hdr_len_q, hdr_port_q;
   logic [31:0] hdr_ip_q;

   logic        pick, any_req, take;
   logic [15:0] sel_len, beat_num;
   logic [7:0]  sg_tdata;
   logic        sg_tvalid, sg_tlast, sg_tuser;
   logic        len_hit, len_mis, pay_last, beat_acc;

   udp_rr_arb2 u_arb (
      .tx_clk  (tx_clk),
      .tx_rst  (tx_rst),
      .req     ({s1_tvalid, s0_tvalid}),
      .take    (take),
      .pick    (pick),
      .any_req (any_req)
   );

   // A zero-length request still consumes exactly one beat, always flagged.
   always_comb begin
      take      = (state == ST_IDLE) && any_req;
      sel_len   = pick ? s1_len : s0_len;
      sg_tdata  = grant_q ? s1_tdata  : s0_tdata;
      sg_tvalid = grant_q ? s1_tvalid : s0_tvalid;
      sg_tlast  = grant_q ? s1_tlast  : s0_tlast;
      sg_tuser  = grant_q ? s1_tuser  : s0_tuser;
      beat_num  = beat_cnt + 16'd1;
      len_hit   = (beat_num == len_q) || (len_q == 16'd0);
      len_mis   = (len_q == 16'd0) || (sg_tlast != len_hit);
      pay_last  = sg_tlast || len_hit;
      beat_acc  = (state == ST_PAY) && sg_tvalid && tx_udp_payload_axis_tready;
   end

   always_ff @(posedge tx_clk) begin
      if (tx_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (any_req) state_nxt = ST_HDR;
         ST_HDR:  if (tx_udp_hdr_ready) state_nxt = ST_PAY;
         ST_PAY:  if (beat_acc && pay_last) state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
         ST_GAP:  if (gap_cnt == 16'd0) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_udp_hdr_valid           = (state == ST_HDR);
      tx_udp_payload_axis_tvalid = 1'b0;
      tx_udp_payload_axis_tdata  = 8'd0;
      tx_udp_payload_axis_tlast  = 1'b0;
      tx_udp_payload_axis_tuser  = 1'b0;
      s0_tready                  = 1'b0;
      s1_tready                  = 1'b0;
      len_err                    = 1'b0;
      if (state == ST_PAY) begin
         tx_udp_payload_axis_tvalid = sg_tvalid;
         tx_udp_payload_axis_tdata  = sg_tdata;
         tx_udp_payload_axis_tlast  = pay_last;
         tx_udp_payload_axis_tuser  = sg_tuser || len_mis;
         s0_tready                  = !grant_q && tx_udp_payload_axis_tready;
         s1_tready                  =  grant_q && tx_udp_payload_axis_tready;
         len_err                    = beat_acc && len_mis;
      end
   end

   always_ff @(posedge tx_clk) begin
      if (tx_rst) begin
         grant_q    <= 1'b0;
         len_q      <= 16'd0;
         beat_cnt   <= 16'd0;
         gap_cnt    <= 16'd0;
         hdr_len_q  <= 16'd0;
         hdr_port_q <= 16'd0;
         hdr_ip_q   <= 32'd0;
      end else begin
         if (take) begin
            grant_q    <= pick;
            len_q      <= sel_len;
            beat_cnt   <= 16'd0;
            hdr_len_q  <= sel_len + UDP_HDR_LEN;
            hdr_port_q <= pick ? DEST_PORT1 : DEST_PORT0;
            hdr_ip_q   <= DEST_IP;
         end else if (beat_acc) begin
            beat_cnt <= beat_num;
         end
         if (beat_acc && pay_last) begin
            gap_cnt <= GAP_LOAD;
         end else if ((state == ST_GAP) && (gap_cnt != 16'd0)) begin
            gap_cnt <= gap_cnt - 16'd1;
         end
      end
   end

   assign grant               = grant_q;
   assign tx_udp_ip_dscp      = 6'd0;
   assign tx_udp_ip_ecn       = 2'd0;
   assign tx_udp_checksum     = 16'd0;
   assign tx_udp_ip_ttl       = TTL;
   assign tx_udp_ip_source_ip = local_ip;
   assign tx_udp_source_port  = src_port;
   assign tx_udp_ip_dest_ip   = hdr_ip_q;
   assign tx_udp_dest_port    = hdr_port_q;
   assign tx_udp_length       = hdr_len_q;

`ifdef UDP_TX_SCHED_STATS_EN
   // Forced-end frames count as completed; all counters wrap naturally.
   always_ff @(posedge tx_clk) begin
      if (tx_rst) begin
         frames0 <= 32'd0;
         frames1 <= 32'd0;
         errs    <= 16'd0;
      end else begin
         if (beat_acc && pay_last) begin
            if (grant_q) frames1 <= frames1 + 32'd1;
            else         frames0 <= frames0 + 32'd1;
         end
         if (len_err) errs <= errs + 16'd1;
      end
   end
`else
   // statistics counters not built
`endif

endmodule

// File: tb/tb_udp_tx_frame_scheduler.sv
// Directed bench with a scoreboard: stimulus queues expected headers/beats,
// a negedge monitor pops and compares whenever the DUT hands something out.
module tb_udp_tx_frame_scheduler;

   typedef struct packed {
      logic [7:0]  data;
      logic        last;
      logic        user;
      logic [15:0] len;
   } in_beat_t;

   typedef struct packed {
      logic [15:0] port;
      logic [15:0] length;
      logic        grant;
   } exp_hdr_t;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       user;
      logic       err;
      logic       grant;
   } exp_beat_t;

   logic        tx_clk, tx_rst;
   logic [31:0] local_ip;
   logic [15:0] src_port;
   logic [15:0] s_len    [2];
   logic [7:0]  s_tdata  [2];
   logic        s_tvalid [2];
   logic        s_tready [2];
   logic        s_tlast  [2];
   logic        s_tuser  [2];
   logic        hdr_valid, hdr_ready;
   logic [5:0]  dscp;
   logic [1:0]  ecn;
   logic [7:0]  ttl;
   logic [31:0] src_ip_o, dest_ip;
   logic [15:0] src_port_o, dest_port, length, checksum;
   logic [7:0]  p_tdata;
   logic        p_tvalid, p_tready, p_tlast, p_tuser;
   logic        len_err, grant;

   in_beat_t  q_in [2][$];
   exp_hdr_t  exp_hdr[$];
   exp_beat_t exp_beat[$];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_cyc = 0;
   logic hv_prev = 1'b0;
   logic have_last = 1'b0;
   logic pend_sample = 1'b0;
   logic pending = 1'b0;

   udp_tx_frame_scheduler dut (
      .tx_clk                     (tx_clk),
      .tx_rst                     (tx_rst),
      .local_ip                   (local_ip),
      .src_port                   (src_port),
      .s0_len                     (s_len[0]),
      .s0_tdata                   (s_tdata[0]),
      .s0_tvalid                  (s_tvalid[0]),
      .s0_tready                  (s_tready[0]),
      .s0_tlast                   (s_tlast[0]),
      .s0_tuser                   (s_tuser[0]),
      .s1_len                     (s_len[1]),
      .s1_tdata                   (s_tdata[1]),
      .s1_tvalid                  (s_tvalid[1]),
      .s1_tready                  (s_tready[1]),
      .s1_tlast                   (s_tlast[1]),
      .s1_tuser                   (s_tuser[1]),
      .tx_udp_hdr_valid           (hdr_valid),
      .tx_udp_hdr_ready           (hdr_ready),
      .tx_udp_ip_dscp             (dscp),
      .tx_udp_ip_ecn              (ecn),
      .tx_udp_ip_ttl              (ttl),
      .tx_udp_ip_source_ip        (src_ip_o),
      .tx_udp_ip_dest_ip          (dest_ip),
      .tx_udp_source_port         (src_port_o),
      .tx_udp_dest_port           (dest_port),
      .tx_udp_length              (length),
      .tx_udp_checksum            (checksum),
      .tx_udp_payload_axis_tdata  (p_tdata),
      .tx_udp_payload_axis_tvalid (p_tvalid),
      .tx_udp_payload_axis_tready (p_tready),
      .tx_udp_payload_axis_tlast  (p_tlast),
      .tx_udp_payload_axis_tuser  (p_tuser),
      .len_err                    (len_err),
      .grant                      (grant)
   );

   initial tx_clk = 1'b0;
   always #5 tx_clk = ~tx_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Input drivers: present queue front, pop once the DUT accepted it.
   task automatic drive_ch(input int c);
      logic     acc;
      in_beat_t b;
      forever begin
         if (q_in[c].size() > 0) begin
            b = q_in[c][0];
            s_tvalid[c] = 1'b1;
            s_tdata[c]  = b.data;
            s_tlast[c]  = b.last;
            s_tuser[c]  = b.user;
            s_len[c]    = b.len;
         end else begin
            s_tvalid[c] = 1'b0;
            s_tdata[c]  = 8'd0;
            s_tlast[c]  = 1'b0;
            s_tuser[c]  = 1'b0;
         end
         @(negedge tx_clk);
         acc = s_tvalid[c] && s_tready[c];
         @(posedge tx_clk);
         #2;
         if (acc && (q_in[c].size() > 0)) void'(q_in[c].pop_front());
      end
   endtask

   initial begin
      s_len[0] = 16'd0;
      drive_ch(0);
   end

   initial begin
      s_len[1] = 16'd0;
      drive_ch(1);
   end

   // Monitor / scoreboard
   initial begin
      exp_hdr_t  h;
      exp_beat_t e;
      forever begin
         @(negedge tx_clk);
         cyc++;
         if (tx_rst) begin
            have_last   = 1'b0;
            pend_sample = 1'b0;
         end else begin
            if (pend_sample) begin
               pending     = s_tvalid[0] || s_tvalid[1];
               pend_sample = 1'b0;
            end
            if (hdr_valid && !hv_prev && have_last) begin
               if (pending) begin
                  chk("gap_to_next_hdr", 64'(cyc - last_cyc), 64'd18);
               end else begin
                  checks++;
                  if ((cyc - last_cyc) < 18) begin
                     errors++;
                     $display("FAIL gap_min: got %0d cycles expected at least 18", cyc - last_cyc);
                  end
               end
               have_last = 1'b0;
            end
            if (hdr_valid && hdr_ready) begin
               if (exp_hdr.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL hdr_unexpected: got port %0d length %0d expected no header", dest_port, length);
               end else begin
                  h = exp_hdr.pop_front();
                  chk("hdr_dest_port", 64'(dest_port), 64'(h.port));
                  chk("hdr_length", 64'(length), 64'(h.length));
                  chk("hdr_grant", 64'(grant), 64'(h.grant));
                  chk("hdr_fixed", {dscp, ecn, checksum, dest_ip, ttl},
                      {6'd0, 2'd0, 16'd0, 32'hEF020206, 8'd64});
               end
            end
            if (p_tvalid && p_tready) begin
               if (exp_beat.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL beat_unexpected: got data %0h expected no beat", p_tdata);
               end else begin
                  e = exp_beat.pop_front();
                  chk("beat_data_last_user_err", {p_tdata, p_tlast, p_tuser, len_err},
                      {e.data, e.last, e.user, e.err});
                  chk("beat_grant", 64'(grant), 64'(e.grant));
               end
               if (p_tlast) begin
                  last_cyc    = cyc;
                  have_last   = 1'b1;
                  pend_sample = 1'b1;
               end
            end else if (len_err) begin
               checks++;
               errors++;
               $display("FAIL len_err_stray: got 1 expected 0 outside an accepted beat");
            end
         end
         hv_prev = hdr_valid;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge tx_clk);
         #1;
      end
   endtask

   task automatic push_frame(input int c, input logic [15:0] len, input int n,
                             input int last_at, input int user_at, input logic [7:0] base);
      in_beat_t b;
      for (int i = 1; i <= n; i++) begin
         b.data = base + 8'(i - 1);
         b.last = (i == last_at);
         b.user = (i == user_at);
         b.len  = len;
         q_in[c].push_back(b);
      end
   endtask

   task automatic eh(input logic [15:0] port, input logic [15:0] len, input logic g);
      exp_hdr_t h;
      h.port   = port;
      h.length = len;
      h.grant  = g;
      exp_hdr.push_back(h);
   endtask

   task automatic eb(input logic [7:0] d, input logic l, input logic u, input logic er, input logic g);
      exp_beat_t e;
      e.data  = d;
      e.last  = l;
      e.user  = u;
      e.err   = er;
      e.grant = g;
      exp_beat.push_back(e);
   endtask

   task automatic wait_done(input string name, input int bound);
      int k;
      k = 0;
      while ((k < bound) && ((exp_hdr.size() != 0) || (exp_beat.size() != 0) ||
                             (q_in[0].size() != 0) || (q_in[1].size() != 0))) begin
         step(1);
         k++;
      end
      checks++;
      if (k >= bound) begin
         errors++;
         $display("FAIL %s_timeout: got %0d hdr / %0d beats outstanding expected 0",
                  name, exp_hdr.size(), exp_beat.size());
         exp_hdr.delete();
         exp_beat.delete();
         q_in[0].delete();
         q_in[1].delete();
      end
      step(20);
   endtask

   task automatic do_reset(input logic check_outputs);
      tx_rst = 1'b1;
      step(3);
      if (check_outputs) begin
         @(negedge tx_clk);
         chk("rst_valids", {hdr_valid, p_tvalid, s_tready[0], s_tready[1], len_err, grant}, 64'd0);
         chk("rst_hdr_data", {length, dest_port, dest_ip}, 64'd0);
         chk("rst_ttl", 64'(ttl), 64'd64);
         chk("rst_src", {src_ip_o, src_port_o}, {local_ip, src_port});
      end
      @(posedge tx_clk);
      #1;
      tx_rst = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      tx_rst    = 1'b1;
      hdr_ready = 1'b1;
      p_tready  = 1'b1;
      local_ip  = 32'h0A00_0001;
      src_port  = 16'd5000;
      step(1);
      do_reset(1'b1);

      // single ch0 frame, len 4
      eh(16'd21007, 16'd12, 1'b0);
      eb(8'hA0, 0, 0, 0, 0); eb(8'hA1, 0, 0, 0, 0); eb(8'hA2, 0, 0, 0, 0); eb(8'hA3, 1, 0, 0, 0);
      push_frame(0, 16'd4, 4, 4, 0, 8'hA0);
      wait_done("single", 300);

      // both channels busy from reset: ch0, ch1, ch0, ch1
      do_reset(1'b0);
      eh(16'd21007, 16'd10, 1'b0); eb(8'hB0, 0, 0, 0, 0); eb(8'hB1, 1, 0, 0, 0);
      eh(16'd21008, 16'd11, 1'b1); eb(8'hC0, 0, 0, 0, 1); eb(8'hC1, 0, 0, 0, 1); eb(8'hC2, 1, 0, 0, 1);
      eh(16'd21007, 16'd9, 1'b0);  eb(8'hB2, 1, 0, 0, 0);
      eh(16'd21008, 16'd9, 1'b1);  eb(8'hC3, 1, 0, 0, 1);
      push_frame(0, 16'd2, 2, 2, 0, 8'hB0);
      push_frame(0, 16'd1, 1, 1, 0, 8'hB2);
      push_frame(1, 16'd3, 3, 3, 0, 8'hC0);
      push_frame(1, 16'd1, 1, 1, 0, 8'hC3);
      wait_done("round_robin", 600);

      // early tlast: len 6, tlast on beat 3
      eh(16'd21008, 16'd14, 1'b1);
      eb(8'hD0, 0, 0, 0, 1); eb(8'hD1, 0, 0, 0, 1); eb(8'hD2, 1, 1, 1, 1);
      push_frame(1, 16'd6, 3, 3, 0, 8'hD0);
      wait_done("early_tlast", 300);

      // len 2 reached without tlast; beats 3..4 become a second frame
      eh(16'd21007, 16'd10, 1'b0); eb(8'hE0, 0, 0, 0, 0); eb(8'hE1, 1, 1, 1, 0);
      eh(16'd21007, 16'd10, 1'b0); eb(8'hE2, 0, 1, 0, 0); eb(8'hE3, 1, 0, 0, 0);
      push_frame(0, 16'd2, 4, 4, 3, 8'hE0);
      wait_done("forced_end", 400);

      // zero-length requests, with and without tlast
      eh(16'd21008, 16'd8, 1'b1); eb(8'hF0, 1, 1, 1, 1);
      eh(16'd21008, 16'd8, 1'b1); eb(8'hF8, 1, 1, 1, 1);
      push_frame(1, 16'd0, 1, 1, 0, 8'hF0);
      push_frame(1, 16'd0, 1, 0, 0, 8'hF8);
      wait_done("zero_len", 400);

      // header back-pressure
      hdr_ready = 1'b0;
      eh(16'd21007, 16'd9, 1'b0); eb(8'h5A, 1, 0, 0, 0);
      push_frame(0, 16'd1, 1, 1, 0, 8'h5A);
      k = 0;
      do begin
         @(negedge tx_clk);
         k++;
      end while (!hdr_valid && (k < 50));
      chk("stall_hdr_seen", 64'(hdr_valid), 64'd1);
      repeat (10) begin
         @(negedge tx_clk);
         chk("stall_hdr_valid", 64'(hdr_valid), 64'd1);
         chk("stall_fields", {length, dest_port}, {16'd9, 16'd21007});
         chk("stall_no_payload", {s_tready[0], s_tready[1], p_tvalid}, 64'd0);
      end
      @(posedge tx_clk);
      #1;
      hdr_ready = 1'b1;
      wait_done("hdr_stall", 300);

      // reset during payload beat 2, then both channels request
      eh(16'd21007, 16'd12, 1'b0); eb(8'h60, 0, 0, 0, 0);
      push_frame(0, 16'd4, 4, 4, 0, 8'h60);
      k = 0;
      do begin
         @(negedge tx_clk);
         k++;
      end while (!(p_tvalid && p_tready && (p_tdata == 8'h60)) && (k < 50));
      chk("midrst_beat1_seen", 64'(p_tdata), 64'h60);
      @(posedge tx_clk);
      #1;
      tx_rst = 1'b1;
      @(posedge tx_clk);
      #1;
      tx_rst = 1'b0;
      q_in[0].delete();
      @(negedge tx_clk);
      chk("midrst_idle", {hdr_valid, p_tvalid, p_tlast, s_tready[0], s_tready[1], len_err, grant}, 64'd0);
      chk("midrst_scoreboard_drained", 64'(exp_hdr.size() + exp_beat.size()), 64'd0);
      exp_hdr.delete();
      exp_beat.delete();
      @(posedge tx_clk);
      #1;
      eh(16'd21007, 16'd9, 1'b0); eb(8'h70, 1, 0, 0, 0);
      eh(16'd21008, 16'd9, 1'b1); eb(8'h71, 1, 0, 0, 1);
      push_frame(0, 16'd1, 1, 1, 0, 8'h70);
      push_frame(1, 16'd1, 1, 1, 0, 8'h71);
      wait_done("after_reset", 300);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/udp_tx_frame_scheduler.md
UDP_TX_FRAME_SCHEDULER -- requirements
Module: udp_tx_frame_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 16: idle tx_clk cycles enforced after each frame's last payload beat.
REQ-002 Parameter DEST_IP, default 32'hEF020206 (239.2.2.6): destination IP for both channels.
REQ-003 Parameter DEST_PORT0 / DEST_PORT1, defaults 21007 / 21008: UDP destination port per channel.
REQ-004 Parameter TTL, default 64: IP TTL for every header.
REQ-005 tx_clk  in  1: sole clock.
REQ-006 tx_rst  in  1: reset; synchronous and active-high.
REQ-007 local_ip  in  32: IP source address. src_port  in  16: UDP source port.
REQ-008 sN_len  in  16, N=0,1: payload byte count, stable while sN_tvalid is high on a frame's first beat.
REQ-009 sN_tdata in 8, sN_tvalid in 1, sN_tready out 1, sN_tlast in 1, sN_tuser in 1: AXIS payload from channel N.
REQ-010 tx_udp_hdr_valid out 1, tx_udp_hdr_ready in 1, plus the header outputs tx_udp_ip_dscp 6, tx_udp_ip_ecn 2, tx_udp_ip_ttl 8, tx_udp_ip_source_ip 32, tx_udp_ip_dest_ip 32, tx_udp_source_port 16, tx_udp_dest_port 16, tx_udp_length 16, tx_udp_checksum 16.
REQ-011 tx_udp_payload_axis_tdata out 8, _tvalid out 1, _tready in 1, _tlast out 1, _tuser out 1.
REQ-012 len_err out 1: one-cycle pulse on a length/tlast mismatch; grant out 1: channel currently owning the output.

Function
REQ-013 The FSM SHALL have four states, IDLE, HDR, PAY and GAP, with the transitions in REQ-014 to REQ-017.
REQ-014 In IDLE with any sN_tvalid high, the block SHALL grant round-robin (ties go to the channel after the last served; ch0 after reset), latch sN_len and the port, and enter HDR on the next cycle.
REQ-015 In HDR, tx_udp_hdr_valid SHALL be 1, with length = latched len + 8, checksum 0, dscp 0 and ecn 0; on valid&&ready the block SHALL enter PAY.
REQ-016 In PAY, the granted channel's tdata, tvalid and tlast SHALL pass combinationally to the output, and sgrant_tready SHALL equal the output tready; the other channel's tready SHALL be 0.
REQ-017 On an accepted beat with output tlast=1, the block SHALL enter GAP; GAP SHALL last exactly GAP_CYCLES cycles and then return to IDLE; GAP_CYCLES=0 SHALL return to IDLE the next cycle.
REQ-018 A 16-bit beat counter SHALL count accepted PAY beats. If tlast arrives with count+1 != len, or count+1 == len without tlast, then out tuser SHALL be 1 on that beat and len_err SHALL pulse.
REQ-019 On the len-reached-without-tlast case, the block SHALL force output tlast=1 and end the frame; remaining input beats form the next request.
REQ-020 Out tuser SHALL be the OR of sN_tuser and the REQ-018 error.
REQ-021 Outside HDR, tx_udp_hdr_valid SHALL be 0; outside PAY, payload tvalid SHALL be 0 and both sN_tready SHALL be 0.
REQ-022 A zero-length request (len=0) SHALL still emit a header with length 8 and one payload beat, flagged per REQ-018.

Reset
REQ-023 On tx_rst, the block SHALL enter IDLE with all valids, treadys, len_err and the counters at 0, the RR pointer at ch0 and grant=0; header data outputs SHALL be 0 except ttl, source_ip and source_port, which track their inputs.
REQ-024 A reset asserted mid-frame SHALL abandon the frame with no tlast emitted; the downstream stack is reset from the same tx_rst.

Configuration
REQ-025 With UDP_TX_SCHED_STATS_EN defined: outputs frames0 32, frames1 32 and errs 16 SHALL count completed frames per channel and len_err pulses, wrap at all-ones, and clear on tx_rst.
REQ-026 Without UDP_TX_SCHED_STATS_EN: those ports and counters SHALL be absent, with all other behaviour identical.

Structure
REQ-027 Package udp_tx_pkg SHALL hold the FSM state encoding, the UDP header length constant 8 and the default ports/IP.
REQ-028 The round-robin grant logic SHALL be a sub-module, udp_rr_arb2.

Verification
REQ-029 Scenario: s0 len=4, 4 beats with tlast on the 4th, hdr_ready=1 -> one header with dest_port 21007 and length 12, then 4 beats with tlast on beat 4, then 16 gap cycles.
REQ-030 Scenario: s0 and s1 both valid from reset -> order ch0, ch1, ch0, ch1; grant alternates.
REQ-031 Scenario: s1 len=6 with tlast on beat 3 -> beat 3 has tlast=1 and tuser=1, len_err pulses once, and the FSM enters GAP.
REQ-032 Scenario: len=2 with no tlast by beat 2 -> output tlast forced on beat 2 with tuser=1; the remaining beats form a new header.
REQ-033 Scenario: hdr_ready held 0 for 10 cycles -> hdr_valid held with stable fields, both sN_tready=0, no payload out.
REQ-034 Scenario: tx_rst pulse at payload beat 2 -> next cycle all valids=0 and IDLE; the next frame is granted to ch0.
